ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked bit
// shifting on device falling edges, acknowledge capture and idle-bus wait.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2400,
  parameter int unsigned REQ_CYCLES     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int unsigned MAX_A  = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_CY = (MAX_A > REQ_CYCLES) ? MAX_A : REQ_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_CY + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]  edge_cnt, edge_n;
  logic [10:0] shreg;
  logic        clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic        fall;
  logic        load, shift, capture, fin, timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    edge_n  = edge_cnt;
    load    = 1'b0;
    shift   = 1'b0;
    capture = 1'b0;
    fin     = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        edge_n = '0;
        if (tx_start) begin
          load    = 1'b1;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n = REQ;
          cnt_n   = '0;
        end
      end
      REQ: begin
        if (cnt == CW'(REQ_CYCLES - 1)) begin
          state_n = SEND;
          cnt_n   = '0;
        end
      end
      SEND: begin
        if (fall) begin
          cnt_n = '0;
          shift = 1'b1;
          // Tenth edge puts the stop bit out; the ACK edge comes next.
          if (edge_cnt == 4'd9) begin
            state_n = ACK;
            edge_n  = '0;
          end else begin
            edge_n = edge_cnt + 4'd1;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_n   = '0;
          capture = 1'b1;
          state_n = WAIT_IDLE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_s2 && dat_s2) begin
          fin     = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (fall) begin
          cnt_n = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      shreg    <= '1;
      ack_ok   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      edge_cnt <= edge_n;
      // Frame is {stop, odd parity, data[7:0], start}; bit 0 is on the wire.
      if (load)
        shreg <= {1'b1, ~^tx_data, tx_data, 1'b0};
      else if (shift)
        shreg <= {1'b1, shreg[10:1]};
      if (load || timeout)
        ack_ok <= 1'b0;
      else if (capture)
        ack_ok <= ~dat_s2;
      done  <= fin | timeout;
      error <= (fin & ~ack_ok) | timeout;
    end
  end

  assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
  assign ps2_dat_oe = ((state == REQ) || (state == SEND)) && !shreg[0];
  assign busy       = (state != IDLE);

endmodule
